// File: rtl/tick_timer.sv
// Programmable countdown timer with one-shot and periodic modes.
// Emits a registered one-cycle tick when the countdown expires.
module tick_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] period,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_start_q;

  logic w_start_edge;
  logic w_period_zero;
  logic w_expire;

  assign w_start_edge  = start & ~r_start_q;
  assign w_period_zero = (period == '0);
  // count is never 0 while running; treating <=1 as expiry also keeps it from wrapping
  assign w_expire      = (r_count <= WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; every branch assigns all three regs, so no hold paths are implied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_tick    <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start;
      case (r_state)
        IDLE: begin
          r_tick <= 1'b0;
          if (w_start_edge && !w_period_zero) begin
            r_count <= period;
            r_state <= RUN;
          end else begin
            r_count <= '0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          // stop outranks a restart, which in turn outranks expiry
          if (stop) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_state <= IDLE;
          end else if (w_start_edge) begin
            r_tick <= 1'b0;
            if (w_period_zero) begin
              r_count <= '0;
              r_state <= IDLE;
            end else begin
              r_count <= period;
              r_state <= RUN;
            end
          end else if (w_expire) begin
            r_tick <= 1'b1;
            if (auto_reload && !w_period_zero) begin
              r_count <= period;
              r_state <= RUN;
            end else begin
              r_count <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_count <= r_count - WIDTH'(1);
            r_tick  <= 1'b0;
            r_state <= RUN;
          end
        end
        default: begin
          r_count <= '0;
          r_tick  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign busy  = (r_state == RUN);

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter: WIDTH, 20, bit width of period and count.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: period  input  WIDTH  reload value in cycles, unsigned.
REQ-005 SHALL have port: start  input  1  level input; only its rising edge acts.
REQ-006 SHALL have port: stop  input  1  level; aborts a running countdown.
REQ-007 SHALL have port: auto_reload  input  1  1 = periodic mode; 0 = one-shot mode.
REQ-008 SHALL have port: count  output  WIDTH  current remaining count, registered.
REQ-009 SHALL have port: tick  output  1  one-cycle expiry pulse, registered.
REQ-010 SHALL have port: busy  output  1  high while state is RUN.

Function
REQ-011 SHALL detect a start edge as start=1 while start_q=0, where start_q is start registered on clock.
REQ-012 SHALL implement two states: IDLE and RUN; busy SHALL be 1 exactly when state=RUN.
REQ-013 In IDLE on a start edge with period!=0, the block SHALL load count<=period, enter RUN, and hold tick=0.
REQ-014 In IDLE on a start edge with period=0, the block SHALL stay in IDLE with count=0 and tick=0.
REQ-015 In IDLE without a start edge, the block SHALL hold count=0 and tick=0, and stop SHALL have no effect.
REQ-016 In RUN with count>1 and no stop and no start edge, the block SHALL set count<=count-1 and tick<=0.
REQ-017 In RUN with count=1, one-shot mode or period=0: the block SHALL set count<=0, tick<=1, and enter IDLE.
REQ-018 In RUN with count=1, auto_reload=1 and period!=0: the block SHALL set count<=period, set tick<=1, and stay in RUN.
REQ-019 The tick period SHALL be exactly N cycles after a load of N, with one tick per expiry and no skipped or duplicated cycles.
REQ-020 period SHALL be sampled only at load or reload; changes mid-run SHALL take effect at the next load.
REQ-021 stop=1 in RUN SHALL set count<=0, tick<=0, and enter IDLE, overriding both expiry and a start edge in the same cycle.
REQ-022 A start edge in RUN without stop SHALL restart the countdown: count<=period (or IDLE if period=0), with no tick, even if count=1.
REQ-023 A start held high for any number of cycles SHALL produce exactly one load.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH; count SHALL never decrement below 0 or wrap to all-ones.
REQ-025 period=2^WIDTH-1 SHALL be legal and SHALL count fully.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, count=0, tick=0, busy=0 and start_q=0.
REQ-027 Reset asserted mid-run SHALL discard the countdown, and no tick SHALL be emitted after reset release.
REQ-028 If start=1 in the first clock after reset release, this SHALL count as a start edge.

Verification
REQ-029 Bench SHALL cover: period=5, auto_reload=0, one-cycle start -> count 5,4,3,2,1,0 on successive edges; tick=1 only in the count=0 cycle; busy falls with that tick.
REQ-030 Bench SHALL cover: period=3, auto_reload=1, start edge -> count 3,2,1,3,2,1,...; tick=1 in each cycle count reloads to 3 (every 3 cycles); busy stays 1.
REQ-031 Bench SHALL cover: period=8, stop=1 when count=2 -> next cycle count=0, busy=0, tick never asserted; stop plus start edge in the same cycle -> IDLE.
REQ-032 Bench SHALL cover: period=4, start held high 10 cycles -> exactly one tick; start edge at count=1 -> count=4, no tick.
REQ-033 Bench SHALL cover: period=0 start edge -> count stays 0, busy=0, tick=0; then period=0xFFFFF -> count=0xFFFFF, then 0xFFFFE.
REQ-034 Bench SHALL cover: reset pulsed asynchronously mid-cycle at count=7 -> count, tick, busy =0 before the next clock edge; no tick afterwards.
